mod12_downcounter: RTL and testbench

Loadable mod-12 down counter with enable, wrap or one-shot mode, terminal-count pulse and sticky done flag. It counts toward zero from a loaded value and is the countdown counterpart to the team's mod-12 up counter. It is used as a countdown timer stage, and its combinational borrow output drives the enable of a higher-order stage when stages are cascaded.

---
 rtl/mod_counter_pkg.sv | 26 ++
 rtl/mod12_downcounter_if.sv | 28 ++
 rtl/mod_down_core.sv | 56 +++++
 rtl/mod12_downcounter.sv | 91 +++++++++
 tb/tb_mod12_downcounter.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mod_counter_pkg.sv
// Shared definitions for the mod-N counter family (down counter and up counter).
// Contents:
//   state_e      - counter control state (IDLE / RUN / DONE), 2-bit encoding
//   DEF_MOD/W    - default modulus and count width
//   clamp_val    - saturate a requested load value into 0..mod-1
//   over_range   - true when a requested load value had to be clamped
package mod_counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_MOD = 12;
    localparam int DEF_W   = 4;

    function automatic int clamp_val(input int v, input int mod);
        return (v > mod - 1) ? (mod - 1) : v;
    endfunction

    function automatic logic over_range(input int v, input int mod);
        return (v > mod - 1);
    endfunction

endpackage

// File: rtl/mod12_downcounter_if.sv
// Control/status bundle of the mod-N down counter.
// master: the controlling logic (drives load/load_val/en/mode/ack, observes status)
// slave : the counter itself (drives count/zero/borrow/tc/done/load_err)
interface mod12_downcounter_if #(
    parameter int W = 4
);
    logic         load;
    logic [W-1:0] load_val;
    logic         en;
    logic         mode;
    logic         ack;
    logic [W-1:0] count;
    logic         zero;
    logic         borrow;
    logic         tc;
    logic         done;
    logic         load_err;

    modport master (
        output load, load_val, en, mode, ack,
        input  count, zero, borrow, tc, done, load_err
    );

    modport slave (
        input  load, load_val, en, mode, ack,
        output count, zero, borrow, tc, done, load_err
    );
endinterface

// File: rtl/mod_down_core.sv
// Count register of the mod-N down counter: load (with clamp), decrement,
// and the wrap-or-stop behaviour at zero.
// Ports:
//   clk, reset   - clock, synchronous active-high reset (count -> 0)
//   load_i       - load clamped load_val_i (takes priority over dec_i)
//   load_val_i   - requested load value
//   dec_i        - consume one count this cycle
//   wrap_i       - at zero: 1 = wrap to MOD-1, 0 = hold at 0
//   count_o      - current count
//   zero_o       - count_o == 0
module mod_down_core
    import mod_counter_pkg::*;
#(
    parameter int MOD = DEF_MOD,
    parameter int W   = DEF_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    input  logic         wrap_i,
    output logic [W-1:0] count_o,
    output logic         zero_o
);
    localparam logic [W-1:0] MAX_CNT = W'(MOD - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = W'(clamp_val(32'(load_val_i), MOD));
        end else if (dec_i) begin
            // Zero is never decremented, so the subtraction cannot underflow.
            if (count_q == '0) begin
                count_d = wrap_i ? MAX_CNT : '0;
            end else begin
                count_d = count_q - W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/mod12_downcounter.sv
// Loadable mod-N down counter (default mod-12) with enable, wrap or one-shot
// mode, registered terminal-count pulse, sticky done flag and load clamp flag.
// borrow is combinational so a higher-order stage can use it as its enable.
// Ports:
//   clk, reset - clock, synchronous active-high reset
//   bus        - slave side of mod12_downcounter_if:
//                in : load, load_val, en, mode, ack
//                out: count, zero, borrow, tc, done, load_err
module mod12_downcounter
    import mod_counter_pkg::*;
#(
    parameter int MOD = DEF_MOD,
    parameter int W   = DEF_W
) (
    input  logic                   clk,
    input  logic                   reset,
    mod12_downcounter_if.slave     bus
);
    state_e       state_q, state_d;
    logic         tc_q, tc_d;
    logic         done_q, done_d;
    logic         load_err_q, load_err_d;

    logic [W-1:0] count;
    logic         zero;
    logic         dec;
    logic         fire;

    // A count is consumed only while running, enabled and not overridden by load.
    assign dec  = (state_q == RUN) && bus.en && !bus.load;
    // The zero count is being consumed this cycle: terminal count.
    assign fire = dec && zero;

    mod_down_core #(
        .MOD (MOD),
        .W   (W)
    ) u_core (
        .clk        (clk),
        .reset      (reset),
        .load_i     (bus.load),
        .load_val_i (bus.load_val),
        .dec_i      (dec),
        .wrap_i     (!bus.mode),
        .count_o    (count),
        .zero_o     (zero)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            tc_q       <= 1'b0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tc_q       <= tc_d;
            done_q     <= done_d;
            load_err_q <= load_err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        tc_d       = fire;
        load_err_d = bus.load && over_range(32'(bus.load_val), MOD);
        if (bus.load) begin
            state_d = RUN;
        end else begin
            unique case (state_q)
                IDLE: state_d = IDLE;
                RUN:  if (fire && bus.mode) state_d = DONE;
                DONE: if (bus.ack) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        done_d = (state_d == DONE);
    end

    // Outputs
    always_comb begin
        bus.count    = count;
        bus.zero     = zero;
        bus.borrow   = fire && !reset;
        bus.tc       = tc_q;
        bus.done     = done_q;
        bus.load_err = load_err_q;
    end

endmodule

// File: tb/tb_mod12_downcounter.sv
module tb_mod12_downcounter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mod12_downcounter_if #(.W(4)) dif ();
    mod12_downcounter_if #(.W(4)) lif ();
    mod12_downcounter_if #(.W(4)) uif ();

    mod12_downcounter #(.MOD(12), .W(4)) dut (.clk(clk), .reset(rst), .bus(dif));

    // Cascade pair: a mod-2 prescaler feeding a mod-12 stage through borrow.
    mod12_downcounter #(.MOD(2),  .W(4)) u_lo (.clk(clk), .reset(rst), .bus(lif));
    mod12_downcounter #(.MOD(12), .W(4)) u_hi (.clk(clk), .reset(rst), .bus(uif));
    assign uif.en = lif.borrow;

    int n_checks = 0;
    int n_errors = 0;
    logic pre_borrow, pre_zero;

    typedef struct {
        logic       ld;
        logic [3:0] lv;
        logic       en;
        logic       mode;
        logic       ack;
        logic       e_borrow;
        logic [3:0] e_count;
        logic       e_tc;
        logic       e_done;
        logic       e_lerr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic ld, input int lv, input logic en, input logic mode,
                                input logic ack, input logic eb, input int ec, input logic etc,
                                input logic ed, input logic el);
        vec_t v;
        v.ld = ld; v.lv = 4'(lv); v.en = en; v.mode = mode; v.ack = ack;
        v.e_borrow = eb; v.e_count = 4'(ec); v.e_tc = etc; v.e_done = ed; v.e_lerr = el;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock of the main counter: drive at negedge, sample borrow/zero just
    // before the rising edge, return #1 after the edge for registered outputs.
    task automatic cyc(input logic r, input logic ld, input int lv, input logic e,
                       input logic m, input logic a);
        @(negedge clk);
        rst = r; dif.load = ld; dif.load_val = 4'(lv); dif.en = e; dif.mode = m; dif.ack = a;
        #4;
        pre_borrow = dif.borrow;
        pre_zero   = dif.zero;
        @(posedge clk);
        #1;
        $display("cyc rst=%0b ld=%0b lv=%0d en=%0b mode=%0b ack=%0b | borrow=%0b -> count=%0d tc=%0b done=%0b lerr=%0b",
                 r, ld, lv, e, m, a, pre_borrow, dif.count, dif.tc, dif.done, dif.load_err);
    endtask

    task automatic chk_post(input string tag, input int c, input logic t, input logic d, input logic l);
        chk({tag, ".count"}, int'(dif.count), c);
        chk({tag, ".tc"}, int'(dif.tc), int'(t));
        chk({tag, ".done"}, int'(dif.done), int'(d));
        chk({tag, ".load_err"}, int'(dif.load_err), int'(l));
    endtask

    // Reference model: plain integers and flags derived from the counting rules.
    int m_cnt;
    bit m_armed, m_fin, m_tc, m_lerr;

    task automatic model_step(input logic r, input logic ld, input int lv, input logic e,
                              input logic m, input logic a);
        if (r) begin
            m_cnt = 0; m_armed = 0; m_fin = 0; m_tc = 0; m_lerr = 0;
        end else if (ld) begin
            m_cnt = (lv > 11) ? 11 : lv;
            m_armed = 1; m_fin = 0; m_tc = 0; m_lerr = (lv > 11);
        end else begin
            m_tc = 0; m_lerr = 0;
            if (m_armed && e) begin
                if (m_cnt == 0) begin
                    m_tc = 1;
                    if (m) begin m_armed = 0; m_fin = 1; end
                    else m_cnt = 11;
                end else begin
                    m_cnt = m_cnt - 1;
                end
            end else if (m_fin && a) begin
                m_fin = 0;
            end
        end
    endtask

    initial begin
        dif.load = 0; dif.load_val = 0; dif.en = 0; dif.mode = 0; dif.ack = 0;
        lif.load = 0; lif.load_val = 0; lif.en = 0; lif.mode = 0; lif.ack = 0;
        uif.load = 0; uif.load_val = 0; uif.mode = 0; uif.ack = 0;

        // Reset state
        cyc(1, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 1, 0, 0);
        chk("reset.borrow", int'(pre_borrow), 0);
        chk_post("reset", 0, 0, 0, 0);
        chk("reset.zero", int'(dif.zero), 1);

        // Table-driven vectors
        vecs.push_back(mk(1, 7, 1, 0, 0, 0, 7, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 6, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 5, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 4, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 3, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 2, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 1, 11, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 10, 0, 0, 0));
        vecs.push_back(mk(1, 13, 0, 0, 0, 0, 11, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 11, 0, 0, 0));
        vecs.push_back(mk(1, 11, 0, 0, 0, 0, 11, 0, 0, 0));
        vecs.push_back(mk(1, 5, 0, 0, 0, 0, 5, 0, 0, 0));
        vecs.push_back(mk(1, 9, 1, 0, 0, 0, 9, 0, 0, 0));
        vecs.push_back(mk(1, 14, 0, 0, 0, 0, 11, 0, 0, 1));
        vecs.push_back(mk(1, 15, 0, 0, 0, 0, 11, 0, 0, 1));
        vecs.push_back(mk(1, 2, 0, 0, 0, 0, 2, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 1, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            cyc(0, vecs[i].ld, int'(vecs[i].lv), vecs[i].en, vecs[i].mode, vecs[i].ack);
            chk({tag, ".borrow"}, int'(pre_borrow), int'(vecs[i].e_borrow));
            chk_post(tag, int'(vecs[i].e_count), vecs[i].e_tc, vecs[i].e_done, vecs[i].e_lerr);
        end

        // One-shot countdown from 3, done sticks, ack returns to idle
        cyc(0, 1, 3, 1, 1, 0);
        chk_post("os.load", 3, 0, 0, 0);
        for (int k = 2; k >= 0; k--) begin
            cyc(0, 0, 0, 1, 1, 0);
            chk_post("os.dec", k, 0, 0, 0);
        end
        cyc(0, 0, 0, 1, 1, 0);
        chk("os.borrow", int'(pre_borrow), 1);
        chk_post("os.fire", 0, 1, 1, 0);
        for (int k = 0; k < 5; k++) begin
            cyc(0, 0, 0, 1, 1, 0);
            chk("os.hold.borrow", int'(pre_borrow), 0);
            chk_post("os.hold", 0, 0, 1, 0);
        end
        cyc(0, 0, 0, 0, 1, 1);
        chk_post("os.ack", 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 0, 1, 0, 0);
            chk_post("os.idle", 0, 0, 0, 0);
        end

        // Load overrides ack in DONE
        cyc(0, 1, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 1, 0);
        chk_post("ldack.done", 0, 1, 1, 0);
        cyc(0, 1, 8, 0, 0, 1);
        chk_post("ldack.load", 8, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        chk_post("ldack.run", 7, 0, 0, 0);

        // Reset mid-count
        cyc(0, 1, 6, 0, 0, 0);
        chk_post("rstrun.load", 6, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0);
        chk_post("rstrun", 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        chk_post("rstrun.en", 0, 0, 0, 0);
        // Reset at count 0 in RUN masks borrow; no wrap afterwards
        cyc(0, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0);
        chk("rstzero.borrow", int'(pre_borrow), 0);
        chk_post("rstzero", 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        chk_post("rstzero.en", 0, 0, 0, 0);
        // Reset in DONE
        cyc(0, 1, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 1, 0);
        chk_post("rstdone.pre", 0, 1, 1, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk_post("rstdone", 0, 0, 0, 0);

        // Randomized run against the reference model
        model_step(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        for (int n = 0; n < 300; n++) begin
            logic r, ld, e, m, a;
            int lv;
            bit eb, ez;
            r  = ($urandom_range(0, 99) < 2);
            ld = ($urandom_range(0, 99) < 12);
            e  = ($urandom_range(0, 99) < 75);
            m  = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 99) < 10);
            lv = int'($urandom_range(0, 15));
            eb = m_armed && e && (m_cnt == 0) && !ld && !r;
            ez = (m_cnt == 0);
            cyc(r, ld, lv, e, m, a);
            model_step(r, ld, lv, e, m, a);
            chk("rnd.borrow", int'(pre_borrow), int'(eb));
            chk("rnd.zero", int'(pre_zero), int'(ez));
            chk_post("rnd", m_cnt, m_tc, m_fin, m_lerr);
        end

        // Cascade: upper stage enabled by lower stage borrow
        @(negedge clk);
        rst = 1; dif.load = 0; dif.en = 0;
        @(negedge clk);
        rst = 0;
        lif.load = 1; lif.load_val = 4'd1; lif.en = 1; lif.mode = 0;
        uif.load = 1; uif.load_val = 4'd2; uif.mode = 0;
        @(posedge clk); #1;
        chk("casc.lo.load", int'(lif.count), 1);
        chk("casc.hi.load", int'(uif.count), 2);
        @(negedge clk);
        lif.load = 0; uif.load = 0;
        begin
            int exp_hi[6] = '{2, 1, 1, 0, 0, 11};
            int exp_lo[6] = '{0, 1, 0, 1, 0, 1};
            for (int k = 0; k < 6; k++) begin
                @(posedge clk); #1;
                $display("casc cyc=%0d lo=%0d hi=%0d hi_tc=%0b", k + 1, lif.count, uif.count, uif.tc);
                chk($sformatf("casc.hi%0d", k + 1), int'(uif.count), exp_hi[k]);
                chk($sformatf("casc.lo%0d", k + 1), int'(lif.count), exp_lo[k]);
            end
            chk("casc.hi.tc", int'(uif.tc), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
